// File: rtl/io_batch_controller.sv
// Batch sequencer for DMA load, CNN compute and interrupt-driven IO transfers.
// Optional DMA watchdog enabled by defining IO_DMA_TIMEOUT_EN.
module io_batch_controller #(
    parameter  int NUM_IMG = 4,
    parameter  int TIMEOUT = 255,
    parameter  int CNT_W   = 8,
    localparam int IDX_W   = $clog2(NUM_IMG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             interrupt,
    input  logic             cnn_img,
    input  logic             dma_done,
    input  logic             abort,
    output logic             io_interface_en,
    output logic             decompressor_en,
    output logic             dma_enable,
    output logic             cnn_enable,
    output logic             done,
    output logic             dma_err,
    output logic [IDX_W-1:0] img_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMG - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DMA  = 3'd1,
        ST_RUN  = 3'd2,
        ST_INT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t           state_r;
    state_t           nxt_state_s;
    logic [IDX_W-1:0] img_idx_r;
    logic [IDX_W-1:0] nxt_idx_s;
    logic             load_q_r;
    logic             res_seen_r;
    logic             load_rise_s;
    logic             timeout_s;
    logic             err_s;
    logic             io_en_r;
    logic             dec_en_r;
    logic             dma_en_r;
    logic             cnn_en_r;
    logic             done_r;
    logic             err_r;

    // Elaboration-time sanity check of the configuration.
    if (NUM_IMG < 2 || TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("io_batch_controller: illegal NUM_IMG/TIMEOUT/CNT_W combination");
    end

    assign load_rise_s = load & ~load_q_r;

`ifdef IO_DMA_TIMEOUT_EN
    logic [CNT_W-1:0] wdog_r;

    // The cycle that would bring the count to TIMEOUT is the last DMA cycle.
    assign timeout_s = (wdog_r == CNT_W'(TIMEOUT - 1));

    // Watchdog: counts consecutive DMA cycles, zero on entry and outside DMA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= '0;
        end else if (state_r == ST_DMA && nxt_state_s == ST_DMA) begin
            wdog_r <= wdog_r + CNT_W'(1);
        end else begin
            wdog_r <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-index decode; abort overrides every transition.
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = img_idx_r;
        err_s       = 1'b0;
        if (abort) begin
            nxt_state_s = ST_IDLE;
            nxt_idx_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_rise_s) begin
                        nxt_state_s = ST_DMA;
                        nxt_idx_s   = '0;
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
                end
                ST_DMA: begin
                    // dma_done beats a coincident watchdog expiry
                    if (dma_done) begin
                        nxt_state_s = ST_RUN;
                    end else if (timeout_s) begin
                        nxt_state_s = ST_IDLE;
                        err_s       = 1'b1;
                    end else begin
                        nxt_state_s = ST_DMA;
                    end
                end
                ST_RUN: begin
                    if (interrupt) begin
                        nxt_state_s = ST_INT;
                    end else begin
                        nxt_state_s = ST_RUN;
                    end
                end
                ST_INT: begin
                    if (interrupt) begin
                        nxt_state_s = ST_INT;
                    end else if (!res_seen_r) begin
                        nxt_state_s = ST_RUN;
                    end else if (img_idx_r == LAST_IDX) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        nxt_state_s = ST_RUN;
                        nxt_idx_s   = img_idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    nxt_state_s = ST_IDLE;
                end
                default: begin
                    nxt_state_s = ST_IDLE;
                    nxt_idx_s   = '0;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            img_idx_r  <= '0;
            load_q_r   <= 1'b0;
            res_seen_r <= 1'b0;
            io_en_r    <= 1'b0;
            dec_en_r   <= 1'b0;
            dma_en_r   <= 1'b0;
            cnn_en_r   <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r   <= nxt_state_s;
            img_idx_r <= nxt_idx_s;
            load_q_r  <= load;
            dma_en_r  <= (nxt_state_s == ST_DMA);
            cnn_en_r  <= (nxt_state_s == ST_RUN);
            done_r    <= (nxt_state_s == ST_DONE);
            err_r     <= err_s;
            dec_en_r  <= (nxt_state_s == ST_INT) & load & cnn_img;
            io_en_r   <= (nxt_state_s == ST_INT) & ~load & cnn_img;
            // res_seen tracks io_interface_en within one INT window
            if (nxt_state_s == ST_INT) begin
                res_seen_r <= res_seen_r | (~load & cnn_img);
            end else begin
                res_seen_r <= 1'b0;
            end
        end
    end

    assign io_interface_en = io_en_r;
    assign decompressor_en = dec_en_r;
    assign dma_enable      = dma_en_r;
    assign cnn_enable      = cnn_en_r;
    assign done            = done_r;
    assign dma_err         = err_r;
    assign img_idx         = img_idx_r;

endmodule

// File: tb/tb_io_batch_controller.sv
// Scoreboard bench for io_batch_controller: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_io_batch_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load, interrupt, cnn_img, dma_done, abort;
    logic       io_interface_en, decompressor_en, dma_enable, cnn_enable, done, dma_err;
    logic [1:0] img_idx;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    // {io, dec, dma, cnn, done, err, idx[1:0]}
    localparam logic [7:0] B_IO   = 8'h80;
    localparam logic [7:0] B_DEC  = 8'h40;
    localparam logic [7:0] B_DMA  = 8'h20;
    localparam logic [7:0] B_RUN  = 8'h10;
    localparam logic [7:0] B_DONE = 8'h08;
    localparam logic [7:0] B_ERR  = 8'h04;
    localparam logic [7:0] B_OFF  = 8'h00;

    io_batch_controller #(.NUM_IMG(4), .TIMEOUT(20), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .interrupt(interrupt),
        .cnn_img(cnn_img), .dma_done(dma_done), .abort(abort),
        .io_interface_en(io_interface_en), .decompressor_en(decompressor_en),
        .dma_enable(dma_enable), .cnn_enable(cnn_enable), .done(done),
        .dma_err(dma_err), .img_idx(img_idx)
    );

    assign outs = {io_interface_en, decompressor_en, dma_enable, cnn_enable,
                   done, dma_err, img_idx};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs; the expected outputs apply after the next edge.
    task automatic step(input logic l, input logic i, input logic c, input logic d,
                        input logic a, input logic [7:0] e, input string nm);
        exp_t item;
        @(posedge clk);
        #2;
        load = l; interrupt = i; cnn_img = c; dma_done = d; abort = a;
        item.due = cyc + 1;
        item.val = e;
        item.nm  = nm;
        exp_q.push_back(item);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk(e.nm, outs, e.val);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        load = 1'b0; interrupt = 1'b0; cnn_img = 1'b0; dma_done = 1'b0; abort = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("reset_state", outs, B_OFF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, B_OFF, "idle");

        // Reset in the middle of DMA
        step(1, 0, 0, 0, 0, B_DMA, "rst_dma_entry");
        step(1, 0, 0, 0, 0, B_DMA, "rst_dma_hold");
        drain();
        load = 1'b0;
        rst_n = 1'b0;
        #1 chk("async_reset_mid_dma", outs, B_OFF);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, B_OFF, "idle_after_reset");
        step(0, 0, 0, 0, 0, B_OFF, "idle_after_reset2");

        // Full batch of 4 result transfers
        step(1, 0, 0, 0, 0, B_DMA, "load_rise");
        for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 0, B_DMA, "dma_wait");
        step(0, 0, 0, 1, 0, B_RUN, "dma_done");
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 0, B_RUN | 8'(k), "run");
            step(0, 1, 1, 0, 0, B_IO | 8'(k), "int_io_entry");
            step(0, 1, 1, 0, 0, B_IO | 8'(k), "int_io_hold");
            if (k < 3) step(0, 0, 1, 0, 0, B_RUN | 8'(k + 1), "int_exit_next_img");
            else       step(0, 0, 1, 0, 0, B_DONE | 8'd3, "done_pulse");
        end
        step(0, 0, 0, 0, 0, B_OFF | 8'd3, "idle_idx_hold");
        step(0, 0, 0, 0, 0, B_OFF | 8'd3, "idle_idx_hold2");

        // Decompress interrupt, non-CNN interrupt, ignored load rise
        step(1, 0, 0, 0, 0, B_DMA, "load_rise_idx_clear");
        step(1, 0, 0, 1, 0, B_RUN, "dma_done2");
        step(1, 1, 1, 0, 0, B_DEC, "int_decomp");
        step(1, 1, 1, 0, 0, B_DEC, "int_decomp_hold");
        step(1, 0, 1, 0, 0, B_RUN, "decomp_exit_idx_same");
        step(0, 0, 0, 0, 0, B_RUN, "run_load_low");
        step(1, 0, 0, 0, 0, B_RUN, "load_rise_ignored");
        step(0, 1, 0, 0, 0, B_OFF, "int_no_cnn_img");
        step(0, 0, 0, 0, 0, B_RUN, "int_no_cnn_exit");
        step(0, 0, 0, 0, 1, B_OFF, "abort_run");

        // dma_done and interrupt together, then abort in INT at img 2
        step(1, 0, 0, 0, 0, B_DMA, "load_rise3");
        step(0, 1, 1, 1, 0, B_RUN, "dma_done_and_int");
        step(0, 1, 1, 0, 0, B_IO, "int_taken_next");
        step(0, 0, 1, 0, 0, B_RUN | 8'd1, "img1");
        step(0, 1, 1, 0, 0, B_IO | 8'd1, "int_img1");
        step(0, 0, 1, 0, 0, B_RUN | 8'd2, "img2");
        step(0, 1, 1, 0, 0, B_IO | 8'd2, "int_img2");
        step(0, 1, 1, 0, 1, B_OFF, "abort_int");
        step(0, 0, 0, 0, 0, B_OFF, "no_done_after_abort");
        step(1, 0, 0, 0, 1, B_OFF, "abort_beats_load");

`ifdef IO_DMA_TIMEOUT_EN
        step(0, 0, 0, 0, 0, B_OFF, "idle_pre_wdog");
        step(1, 0, 0, 0, 0, B_DMA, "wdog_entry");
        for (int k = 0; k < 19; k++) step(0, 0, 0, 0, 0, B_DMA, "wdog_count");
        step(0, 0, 0, 0, 0, B_ERR, "wdog_timeout");
        step(0, 0, 0, 0, 0, B_OFF, "wdog_err_one_cycle");
        step(1, 0, 0, 0, 0, B_DMA, "wdog_entry2");
        for (int k = 0; k < 19; k++) step(0, 0, 0, 0, 0, B_DMA, "wdog_count2");
        step(0, 0, 0, 1, 0, B_RUN, "wdog_done_wins");
        step(0, 0, 0, 0, 1, B_OFF, "wdog_abort");
`else
        step(0, 0, 0, 0, 0, B_OFF, "idle_pre_wait");
        step(1, 0, 0, 0, 0, B_DMA, "dma_forever_entry");
        for (int k = 0; k < 310; k++) step(0, 0, 0, 0, 0, B_DMA, "dma_no_timeout");
        step(0, 0, 0, 0, 1, B_OFF, "dma_abort");
`endif
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_batch_controller.md
# io_batch_controller

Clocked, parametrised successor to the combinational/edge-triggered IO control logic. It sequences one batch of `NUM_IMG` images through DMA load, CNN compute, and interrupt-driven IO transfers. It sits between the host IO interface, the DMA engine, the decompressor and the CNN core, and drives their enables from a single registered FSM. It counts completed result transfers and raises `done` once the batch finishes.

## Interface
- `NUM_IMG`, 4, images per batch (≥2); `IDX_W = $clog2(NUM_IMG)` is a derived localparam.
- `TIMEOUT`, 255, DMA watchdog limit in cycles (1..2^`CNT_W`-1); used only with `IO_DMA_TIMEOUT_EN`.
- `CNT_W`, 8, watchdog counter width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  host load request; rising edge starts a batch; level selects decompress (1) vs result output (0) during interrupt.
- `interrupt`  in  1  IO transfer window; high pauses CNN.
- `cnn_img`  in  1  transfer concerns CNN image data.
- `dma_done`  in  1  DMA completion level/pulse.
- `abort`  in  1  synchronous batch abort.
- `io_interface_en`  out  1  result-output path enable.
- `decompressor_en`  out  1  decompressor enable.
- `dma_enable`  out  1  DMA run.
- `cnn_enable`  out  1  CNN run.
- `done`  out  1  one-cycle batch-complete pulse.
- `dma_err`  out  1  one-cycle watchdog-timeout pulse.
- `img_idx`  out  IDX_W  index of the current image, 0..NUM_IMG-1.

## Operation
- Inputs are synchronous to `clk`. `load` rise is detected as `load & !load_q`, where `load_q` is a registered copy.
- States:
  - IDLE: all enables 0. A `load` rise moves to DMA and clears `img_idx` to 0.
  - DMA: `dma_enable`=1. `dma_done`=1 moves to RUN.
  - RUN: `cnn_enable`=1. `interrupt`=1 moves to INT.
  - INT: `cnn_enable`=0. `decompressor_en` = `load & cnn_img`; `io_interface_en` = `!load & cnn_img`, recomputed every cycle. A `res_seen` flag sets while `io_interface_en` is asserted. On `interrupt`=0:
    - If `res_seen` is clear, move to RUN.
    - If `res_seen` is set and `img_idx`==NUM_IMG-1, move to DONE.
    - If `res_seen` is set otherwise, increment `img_idx` and move to RUN.
    - `res_seen` clears on INT exit.
  - DONE: `done`=1 for one cycle, then IDLE; `img_idx` holds its final value until the next `load` rise.
- `decompressor_en` and `io_interface_en` are never both 1 and are 0 outside INT.
- A `load` rise outside IDLE is ignored.
- `abort`=1 in any state goes to IDLE next cycle; all enables drop and `img_idx` clears. `abort` has priority over every other transition.
- If `dma_done` and `interrupt` are both high in DMA, the FSM goes to RUN; the interrupt is taken on the following cycle.
- `interrupt` already high on entering RUN causes INT on the next cycle.

## Timing
- All outputs are registered, decoded from the next state: an output changes on the clock edge that samples the triggering input (1-cycle latency).
  - `load` rise at edge N → `dma_enable`=1 after edge N.
  - `dma_done` at edge M → `dma_enable`=0 and `cnn_enable`=1 after edge M.
- Reset values: all outputs 0, `img_idx`=0, state IDLE, `load_q`=0, watchdog=0. Reset is asynchronous and effective mid-batch.
- Minimum batch: 1 (DMA) + NUM_IMG×(1 RUN + 1 INT) + 1 (DONE) cycles after the `load` rise.

## Configuration
- `IO_DMA_TIMEOUT_EN` defined:
  - The watchdog counts cycles in DMA, starting at 0 on entry.
  - When the count reaches `TIMEOUT` with no `dma_done`, the FSM goes to IDLE, `dma_enable` drops, and `dma_err`=1 for one cycle.
  - If `dma_done` and the timeout coincide, `dma_done` wins (RUN, no error).
  - `abort` wins over both.
- `IO_DMA_TIMEOUT_EN` undefined: no counter; `dma_err` is tied 0; DMA waits indefinitely.

## Test plan
- Reset mid-DMA: assert `rst_n`=0 asynchronously → all outputs 0 immediately, `img_idx`=0; releasing reset leaves the FSM in IDLE.
- Full batch, NUM_IMG=4: `load` rise, `dma_done` after 10 cycles, then 4 interrupts with `load`=0, `cnn_img`=1 → `io_interface_en` high in each window, `img_idx` 0→1→2→3, `done` pulses once after the 4th interrupt falls, then IDLE.
- Decompress interrupt: in RUN, raise `interrupt` with `load`=1, `cnn_img`=1 → `cnn_enable`=0, `decompressor_en`=1. On release → back to RUN, `img_idx` unchanged.
- Simultaneous events: `dma_done` and `interrupt` high in the same DMA cycle → one cycle of `cnn_enable`=1, then INT. A second `load` rise during RUN is ignored.
- Abort: `abort`=1 during INT with `img_idx`=2 → next cycle all enables 0, `img_idx`=0, no `done`.
- Watchdog (macro on, TIMEOUT=20): no `dma_done` → `dma_err` pulses at cycle 20 of DMA and the FSM returns to IDLE. With `dma_done` at cycle 20 → RUN and no `dma_err`. Macro off → stays in DMA beyond 300 cycles.
